// File: rtl/mostra_pkg.sv
// rtl/mostra_pkg.sv - shared state encodings and timing defaults for sequence playback
package mostra_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        BUSCA   = 3'd1,
        ESPERA  = 3'd2,
        ACESO   = 3'd3,
        APAGADO = 3'd4,
        FIM     = 3'd5
    } estado_t;

    localparam int T_ON_DEF  = 500;
    localparam int T_OFF_DEF = 250;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/temporizador_mostra.sv
// rtl/temporizador_mostra.sv - up-counter with runtime terminal value and end-of-period pulse
module temporizador_mostra #(
    parameter int W = 9
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         limpar,
    input  logic         habilitar,
    input  logic [W-1:0] terminal,
    output logic         fim
);

    logic [W-1:0] conta;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            conta <= '0;
        end else if (limpar) begin
            conta <= '0;
        end else if (habilitar) begin
            conta <= conta + W'(1);
        end
    end

    // Fires on the last cycle of the period so the caller can switch state on that edge.
    assign fim = habilitar && (conta == terminal - W'(1));

endmodule

// File: rtl/mostra_sequencia.sv
// rtl/mostra_sequencia.sv - plays the stored sequence from address 0 up to the current round on the LEDs
module mostra_sequencia
    import mostra_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4,
    parameter int T_ON   = T_ON_DEF,
    parameter int T_OFF  = T_OFF_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              iniciar,
    input  logic              cancelar,
    input  logic [ADDR_W-1:0] rodada,
    input  logic [DATA_W-1:0] mem_dado,
    output logic [ADDR_W-1:0] mem_endereco,
    output logic [DATA_W-1:0] leds,
    output logic              ocupado,
    output logic              pronto,
    output logic [2:0]        db_estado
);

    localparam int TW = $clog2(max_int(T_ON, T_OFF) + 1);

    estado_t           estado, proximo;
    logic [ADDR_W-1:0] endereco, rodada_r;
    logic [DATA_W-1:0] dado_r, leds_next;
    logic              tmr_limpar, tmr_habilitar, tmr_fim;
    logic [TW-1:0]     tmr_terminal;

    temporizador_mostra #(.W(TW)) u_temporizador (
        .clock     (clock),
        .reset_n   (reset_n),
        .limpar    (tmr_limpar),
        .habilitar (tmr_habilitar),
        .terminal  (tmr_terminal),
        .fim       (tmr_fim)
    );

    always_comb begin
        proximo       = estado;
        tmr_limpar    = 1'b0;
        tmr_habilitar = 1'b0;
        tmr_terminal  = TW'(T_ON);
        case (estado)
            IDLE:    if (iniciar) proximo = BUSCA;
            BUSCA:   proximo = ESPERA;
            ESPERA: begin
                tmr_limpar = 1'b1;
                proximo    = ACESO;
            end
            ACESO: begin
                tmr_habilitar = 1'b1;
                if (tmr_fim) begin
                    tmr_limpar = 1'b1;
                    proximo    = APAGADO;
                end
            end
            APAGADO: begin
                tmr_habilitar = 1'b1;
                tmr_terminal  = TW'(T_OFF);
                if (tmr_fim) begin
                    tmr_limpar = 1'b1;
                    proximo    = (endereco == rodada_r) ? FIM : BUSCA;
                end
            end
            FIM:     proximo = IDLE;
            default: proximo = IDLE;
        endcase
        // Abort wins over everything, including a simultaneous start in IDLE.
        if (cancelar) begin
            proximo    = IDLE;
            tmr_limpar = 1'b1;
        end
    end

    // LEDs are registered from the next state so they change only on clock edges.
    always_comb begin
        leds_next = '0;
        if (proximo == ACESO) begin
            leds_next = (estado == ESPERA) ? mem_dado : dado_r;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado   <= IDLE;
            endereco <= '0;
            rodada_r <= '0;
            dado_r   <= '0;
            leds     <= '0;
        end else begin
            estado <= proximo;
            leds   <= leds_next;
            if (cancelar) begin
                endereco <= '0;
            end else if (estado == IDLE && iniciar) begin
                rodada_r <= rodada;
                endereco <= '0;
            end else if (estado == APAGADO && tmr_fim && endereco != rodada_r) begin
                endereco <= endereco + ADDR_W'(1);
            end
            if (estado == ESPERA) begin
                dado_r <= mem_dado;
            end
        end
    end

    assign mem_endereco = endereco;
    assign ocupado      = (estado != IDLE);
    assign pronto       = (estado == FIM);
    assign db_estado    = estado;

endmodule
